rupt_ctrl: RTL and testbench

//  Interrupt (RUPT) controller for the AGC pipeline. Latches RUPT requests and selects the highest-priority one.

---
 rtl/rupt_ctrl_pkg.sv | 33 +++
 rtl/rupt_prio_enc.sv | 22 ++
 rtl/rupt_ctrl.sv | 132 +++++++++++++
 tb/tb_rupt_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rupt_ctrl_pkg.sv
// Shared AGC interrupt definitions: controller states, vector layout and request line indices.
package rupt_ctrl_pkg;

    typedef enum logic [1:0] {
        RUPT_IDLE,
        RUPT_INJECT,
        RUPT_ACTIVE,
        RUPT_RESTORE
    } rupt_state_t;

    localparam int unsigned RUPT_NUM        = 10;
    localparam logic [11:0] RUPT_VEC_BASE   = 12'o4000;
    localparam int unsigned RUPT_VEC_STRIDE = 4;

    localparam int unsigned T6RUPT    = 0;
    localparam int unsigned T5RUPT    = 1;
    localparam int unsigned T3RUPT    = 2;
    localparam int unsigned T4RUPT    = 3;
    localparam int unsigned KEYRUPT1  = 4;
    localparam int unsigned KEYRUPT2  = 5;
    localparam int unsigned UPRUPT    = 6;
    localparam int unsigned DOWNRUPT  = 7;
    localparam int unsigned RADARRUPT = 8;
    localparam int unsigned HANDRUPT  = 9;

    // Vector address wraps within the 12-bit fixed-fetch address space.
    function automatic logic [11:0] rupt_vec_addr(input logic [11:0] base,
                                                  input int unsigned stride,
                                                  input int unsigned idx);
        return base + 12'(stride * idx);
    endfunction

endpackage

// File: rtl/rupt_prio_enc.sv
// Lowest-set-bit priority encoder for RUPT requests; bit 0 is the highest priority.
module rupt_prio_enc #(
    parameter int unsigned N = 10,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/rupt_ctrl.sv
// AGC RUPT controller: latches requests, injects the highest priority one at a safe boundary.
// Optional RUPT LOCK alarm counter built when RUPT_LOCK_EN is defined.
module rupt_ctrl
    import rupt_ctrl_pkg::*;
#(
    parameter int unsigned NUM_RUPT   = RUPT_NUM,
    parameter logic [11:0] VEC_BASE   = RUPT_VEC_BASE,
    parameter int unsigned VEC_STRIDE = RUPT_VEC_STRIDE
`ifdef RUPT_LOCK_EN
    , parameter int unsigned LOCK_LIMIT = 4095
`endif
) (
    input  logic                clock,
    input  logic                rst_l,
    input  logic [NUM_RUPT-1:0] rupt_req,
    input  logic                inhint_exec,
    input  logic                relint_exec,
    input  logic                extend_pend,
    input  logic                index_pend,
    input  logic                a_ovf,
    input  logic                stall,
    input  logic                resume_exec,
    input  logic [11:0]         pc_d,
    output logic                flush,
    output logic                redir_en,
    output logic [11:0]         redir_pc,
    output logic                zrupt_we,
    output logic [11:0]         zrupt_d,
    output logic                in_rupt,
    output logic [NUM_RUPT-1:0] pending,
    output logic                rupt_lock
);

    localparam int unsigned IDX_W = (NUM_RUPT > 1) ? $clog2(NUM_RUPT) : 1;

    rupt_state_t         state, state_n;
    logic                inhibit;
    logic [11:0]         saved_pc;
    logic [NUM_RUPT-1:0] clr_mask;
    logic                prio_valid;
    logic [IDX_W-1:0]    prio_idx;
    logic                safe;

    rupt_prio_enc #(
        .N (NUM_RUPT),
        .W (IDX_W)
    ) u_prio (
        .req   (pending),
        .valid (prio_valid),
        .idx   (prio_idx)
    );

    assign in_rupt = (state == RUPT_ACTIVE);
    assign safe    = ~inhibit & ~extend_pend & ~index_pend & ~a_ovf & ~stall & ~in_rupt;

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            state    <= RUPT_IDLE;
            inhibit  <= 1'b1;
            saved_pc <= '0;
            pending  <= '0;
        end else begin
            state <= state_n;
            if (inhint_exec)
                inhibit <= 1'b1;
            else if (relint_exec)
                inhibit <= 1'b0;
            if (zrupt_we)
                saved_pc <= pc_d;
            // New request on the serviced line survives its own clear.
            pending <= (pending & ~clr_mask) | rupt_req;
        end
    end

    always_comb begin
        state_n  = state;
        flush    = 1'b0;
        redir_en = 1'b0;
        redir_pc = '0;
        zrupt_we = 1'b0;
        zrupt_d  = '0;
        clr_mask = '0;
        case (state)
            RUPT_IDLE: begin
                if (prio_valid && safe)
                    state_n = RUPT_INJECT;
            end
            RUPT_INJECT: begin
                if (prio_valid && safe) begin
                    flush    = 1'b1;
                    redir_en = 1'b1;
                    redir_pc = rupt_vec_addr(VEC_BASE, VEC_STRIDE, 32'(prio_idx));
                    zrupt_we = 1'b1;
                    zrupt_d  = pc_d;
                    clr_mask = NUM_RUPT'(1) << prio_idx;
                    state_n  = RUPT_ACTIVE;
                end else begin
                    state_n = RUPT_IDLE;
                end
            end
            RUPT_ACTIVE: begin
                if (resume_exec)
                    state_n = RUPT_RESTORE;
            end
            RUPT_RESTORE: begin
                flush    = 1'b1;
                redir_en = 1'b1;
                redir_pc = saved_pc;
                state_n  = RUPT_IDLE;
            end
            default: state_n = RUPT_IDLE;
        endcase
    end

`ifdef RUPT_LOCK_EN
    logic [11:0] lock_cnt;

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l)
            lock_cnt <= '0;
        else if (!(inhibit || in_rupt))
            lock_cnt <= '0;
        else if (lock_cnt != 12'(LOCK_LIMIT))
            lock_cnt <= lock_cnt + 12'd1;
    end

    assign rupt_lock = (lock_cnt == 12'(LOCK_LIMIT));
`else
    assign rupt_lock = 1'b0;
`endif

endmodule

// File: tb/tb_rupt_ctrl.sv
// Directed self-checking bench for rupt_ctrl (lock alarm scenario active when RUPT_LOCK_EN is defined).
module tb_rupt_ctrl;

    logic        clock = 1'b0;
    logic        rst_l = 1'b0;
    logic [9:0]  rupt_req = '0;
    logic        inhint_exec = 1'b0, relint_exec = 1'b0;
    logic        extend_pend = 1'b0, index_pend = 1'b0, a_ovf = 1'b0, stall = 1'b0;
    logic        resume_exec = 1'b0;
    logic [11:0] pc_d = '0;
    logic        flush, redir_en, zrupt_we, in_rupt, rupt_lock;
    logic [11:0] redir_pc, zrupt_d;
    logic [9:0]  pending;

    int checks = 0;
    int errors = 0;

    rupt_ctrl #(
        .NUM_RUPT   (10),
        .VEC_BASE   (12'o4000),
        .VEC_STRIDE (4)
`ifdef RUPT_LOCK_EN
        , .LOCK_LIMIT (16)
`endif
    ) dut (
        .clock       (clock),
        .rst_l       (rst_l),
        .rupt_req    (rupt_req),
        .inhint_exec (inhint_exec),
        .relint_exec (relint_exec),
        .extend_pend (extend_pend),
        .index_pend  (index_pend),
        .a_ovf       (a_ovf),
        .stall       (stall),
        .resume_exec (resume_exec),
        .pc_d        (pc_d),
        .flush       (flush),
        .redir_en    (redir_en),
        .redir_pc    (redir_pc),
        .zrupt_we    (zrupt_we),
        .zrupt_d     (zrupt_d),
        .in_rupt     (in_rupt),
        .pending     (pending),
        .rupt_lock   (rupt_lock)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        rst_l = 1'b0;
        rupt_req = '0; inhint_exec = 0; relint_exec = 0;
        extend_pend = 0; index_pend = 0; a_ovf = 0; stall = 0; resume_exec = 0;
        step(); step();
        rst_l = 1'b1;
    endtask

    // Finish an ongoing service: one ACTIVE cycle, RESUME, RESTORE, back to IDLE.
    task automatic finish_service();
        step();
        resume_exec = 1'b1;
        step();
        resume_exec = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        step();
        checks++;
        if ({flush, redir_en, zrupt_we, in_rupt, rupt_lock} !== 5'b0 || redir_pc !== 12'o0 ||
            zrupt_d !== 12'o0 || pending !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got flush=%b redir_en=%b we=%b in_rupt=%b lock=%b pc=%o zd=%o pend=%b want all 0",
                     flush, redir_en, zrupt_we, in_rupt, rupt_lock, redir_pc, zrupt_d, pending);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        relint_exec = 1'b1;
        step();
        relint_exec = 1'b0;
        pc_d = 12'o3012;
        rupt_req = 10'b0000001000;
        step();
        rupt_req = '0;
        checks++;
        if (flush !== 1'b0 || pending !== 10'b0000001000) begin
            errors++;
            $display("FAIL basic_latch: got flush=%b pending=%b want flush=0 pending=0000001000", flush, pending);
        end
        step();
        checks++;
        if (flush !== 1'b1 || redir_en !== 1'b1 || zrupt_we !== 1'b1) begin
            errors++;
            $display("FAIL basic_inject_strobes: got flush=%b redir_en=%b we=%b want 1 1 1", flush, redir_en, zrupt_we);
        end
        checks++;
        if (redir_pc !== 12'o4014 || zrupt_d !== 12'o3012) begin
            errors++;
            $display("FAIL basic_inject_addr: got redir_pc=%o zrupt_d=%o want 4014 3012", redir_pc, zrupt_d);
        end
        step();
        checks++;
        if (in_rupt !== 1'b1 || flush !== 1'b0 || pending !== 10'b0) begin
            errors++;
            $display("FAIL basic_active: got in_rupt=%b flush=%b pending=%b want 1 0 0", in_rupt, flush, pending);
        end
        pc_d = 12'o7777;
        resume_exec = 1'b1;
        step();
        resume_exec = 1'b0;
        checks++;
        if (flush !== 1'b1 || redir_en !== 1'b1 || redir_pc !== 12'o3012 || in_rupt !== 1'b0 || zrupt_we !== 1'b0) begin
            errors++;
            $display("FAIL basic_restore: got flush=%b redir_en=%b pc=%o in_rupt=%b we=%b want 1 1 3012 0 0",
                     flush, redir_en, redir_pc, in_rupt, zrupt_we);
        end
        step();
    endtask

    task automatic test_priority();
        pc_d = 12'o1234;
        rupt_req = 10'b0010000100;
        step();
        rupt_req = '0;
        step();
        checks++;
        if (flush !== 1'b1 || redir_pc !== 12'o4010) begin
            errors++;
            $display("FAIL prio_first: got flush=%b redir_pc=%o want 1 4010", flush, redir_pc);
        end
        step();
        checks++;
        if (pending !== 10'b0010000000) begin
            errors++;
            $display("FAIL prio_pending: got %b want 0010000000", pending);
        end
        step();
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL prio_no_nest: got flush=%b want 0", flush);
        end
        pc_d = 12'o0100;
        resume_exec = 1'b1;
        step();
        resume_exec = 1'b0;
        checks++;
        if (flush !== 1'b1 || redir_pc !== 12'o1234) begin
            errors++;
            $display("FAIL prio_restore: got flush=%b redir_pc=%o want 1 1234", flush, redir_pc);
        end
        step();
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL prio_gap: got flush=%b want 0", flush);
        end
        step();
        checks++;
        if (flush !== 1'b1 || redir_pc !== 12'o4034 || zrupt_d !== 12'o0100) begin
            errors++;
            $display("FAIL prio_second: got flush=%b redir_pc=%o zrupt_d=%o want 1 4034 0100", flush, redir_pc, zrupt_d);
        end
        finish_service();
    endtask

    task automatic test_blockers();
        for (int b = 0; b < 4; b++) begin
            rupt_req = 10'b0000000010;
            case (b)
                0: extend_pend = 1'b1;
                1: index_pend  = 1'b1;
                2: a_ovf       = 1'b1;
                default: stall = 1'b1;
            endcase
            step();
            rupt_req = '0;
            for (int c = 0; c < 3; c++) begin
                step();
                checks++;
                if (flush !== 1'b0 || pending !== 10'b0000000010) begin
                    errors++;
                    $display("FAIL blocker%0d_hold cycle %0d: got flush=%b pending=%b want 0 0000000010", b, c, flush, pending);
                end
            end
            extend_pend = 1'b0; index_pend = 1'b0; a_ovf = 1'b0; stall = 1'b0;
            step();
            checks++;
            if (flush !== 1'b1 || redir_pc !== 12'o4004) begin
                errors++;
                $display("FAIL blocker%0d_release: got flush=%b redir_pc=%o want 1 4004", b, flush, redir_pc);
            end
            finish_service();
        end
    endtask

    task automatic test_inhint();
        inhint_exec = 1'b1;
        step();
        inhint_exec = 1'b0;
        rupt_req = 10'b0000000001;
        step();
        rupt_req = '0;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (flush !== 1'b0 || pending !== 10'b0000000001) begin
                errors++;
                $display("FAIL inhint_hold cycle %0d: got flush=%b pending=%b want 0 0000000001", c, flush, pending);
            end
        end
        relint_exec = 1'b1;
        step();
        relint_exec = 1'b0;
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL relint_early: got flush=%b want 0", flush);
        end
        step();
        checks++;
        if (flush !== 1'b1 || redir_pc !== 12'o4000) begin
            errors++;
            $display("FAIL relint_inject: got flush=%b redir_pc=%o want 1 4000", flush, redir_pc);
        end
        finish_service();
    endtask

    task automatic test_reset_mid_service();
        rupt_req = 10'b0000000001;
        step();
        rupt_req = '0;
        step();
        step();
        rupt_req = 10'b0100000000;
        step();
        rupt_req = '0;
        checks++;
        if (in_rupt !== 1'b1 || pending !== 10'b0100000000) begin
            errors++;
            $display("FAIL midrst_setup: got in_rupt=%b pending=%b want 1 0100000000", in_rupt, pending);
        end
        #2;
        rst_l = 1'b0;
        #1;
        checks++;
        if ({flush, redir_en, zrupt_we, in_rupt} !== 4'b0 || pending !== 10'b0 || redir_pc !== 12'o0) begin
            errors++;
            $display("FAIL midrst_async: got flush=%b redir_en=%b we=%b in_rupt=%b pending=%b pc=%o want all 0",
                     flush, redir_en, zrupt_we, in_rupt, pending, redir_pc);
        end
        step();
        rst_l = 1'b1;
        rupt_req = 10'b0000000001;
        step();
        rupt_req = '0;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (flush !== 1'b0 || in_rupt !== 1'b0) begin
                errors++;
                $display("FAIL midrst_inhibit cycle %0d: got flush=%b in_rupt=%b want 0 0", c, flush, in_rupt);
            end
        end
        relint_exec = 1'b1;
        step();
        relint_exec = 1'b0;
        step();
        checks++;
        if (flush !== 1'b1 || redir_pc !== 12'o4000) begin
            errors++;
            $display("FAIL midrst_relint_inject: got flush=%b redir_pc=%o want 1 4000", flush, redir_pc);
        end
        finish_service();
    endtask

    task automatic test_lock();
        apply_reset();
`ifdef RUPT_LOCK_EN
        for (int c = 1; c <= 16; c++) begin
            step();
            checks++;
            if (rupt_lock !== (c == 16)) begin
                errors++;
                $display("FAIL lock_count cycle %0d: got rupt_lock=%b want %b", c, rupt_lock, (c == 16));
            end
        end
        relint_exec = 1'b1;
        step();
        relint_exec = 1'b0;
        step();
        checks++;
        if (rupt_lock !== 1'b0) begin
            errors++;
            $display("FAIL lock_clear: got rupt_lock=%b want 0", rupt_lock);
        end
`else
        for (int c = 0; c < 40; c++) begin
            step();
            checks++;
            if (rupt_lock !== 1'b0) begin
                errors++;
                $display("FAIL lock_tied cycle %0d: got rupt_lock=%b want 0", c, rupt_lock);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_blockers();
        test_inhint();
        test_reset_mid_service();
        test_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
